div_share_arbiter: RTL

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_share_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/div_share_arbiter.sv
// Two-requester round-robin front end for one shared iterative divider.
// Handles divide-by-zero locally and bounds the wait for div_done with a timeout.
module div_share_arbiter #(
  parameter int N       = 48,
  parameter int TIMEOUT = 2*N+8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_m,
  input  logic [N-1:0]     req0_q,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_m,
  input  logic [N-1:0]     req1_q,
  output logic             div_start,
  output logic [N-1:0]     div_m,
  output logic [N-1:0]     div_q,
  input  logic             div_done,
  input  logic [N/2-1:0]   div_quot,
  input  logic [N/2-1:0]   div_rem,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N/2-1:0]   rsp_quot,
  output logic [N/2-1:0]   rsp_rem,
  output logic             rsp_dbz,
  output logic             rsp_tmo,
  output logic             busy
);

  localparam int HW = N/2;
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [N-1:0]  ZERO_N   = {N{1'b0}};
  localparam logic [HW-1:0] ZERO_H   = {HW{1'b0}};
  localparam logic [HW-1:0] ONES_H   = {HW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            last_q;
  logic            div_start_q;
  logic [N-1:0]    div_m_q;
  logic [N-1:0]    div_q_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [HW-1:0]   rsp_quot_q;
  logic [HW-1:0]   rsp_rem_q;
  logic            rsp_dbz_q;
  logic            rsp_tmo_q;
  logic            busy_q;

  logic            gnt_any_s;
  logic            gnt_id_s;
  logic            fire_s;
  logic [N-1:0]    sel_m_s;
  logic [N-1:0]    sel_q_s;

  // Grant selection and ready generation; a tie goes to the requester not served last.
  always_comb begin
    gnt_any_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id_s = ~last_q;
    end else if (req1_valid) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    if ((state_q == S_IDLE) && rstn) begin
      req0_ready = gnt_any_s & ~gnt_id_s;
      req1_ready = gnt_any_s & gnt_id_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    fire_s  = req0_ready | req1_ready;
    sel_m_s = gnt_id_s ? req1_m : req0_m;
    sel_q_s = gnt_id_s ? req1_q : req0_q;
    cnt_d   = cnt_q + CW'(1);
  end

  // Control FSM with all outputs registered; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      div_start_q <= 1'b0;
      div_m_q     <= ZERO_N;
      div_q_q     <= ZERO_N;
      cnt_q       <= CNT_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_quot_q  <= ZERO_H;
      rsp_rem_q   <= ZERO_H;
      rsp_dbz_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fire_s) begin
            div_m_q  <= sel_m_s;
            div_q_q  <= sel_q_s;
            rsp_id_q <= gnt_id_s;
            last_q   <= gnt_id_s;
            busy_q   <= 1'b1;
            if (sel_m_s == ZERO_N) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_dbz_q   <= 1'b1;
              rsp_tmo_q   <= 1'b0;
              rsp_quot_q  <= ONES_H;
              rsp_rem_q   <= ZERO_H;
            end else begin
              state_q     <= S_ISSUE;
              div_start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_ZERO;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // div_done takes priority over a simultaneous timeout.
          if (div_done) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_quot_q  <= div_quot;
            rsp_rem_q   <= div_rem;
            rsp_dbz_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_quot_q  <= ZERO_H;
            rsp_rem_q   <= ZERO_H;
            rsp_dbz_q   <= 1'b0;
            rsp_tmo_q   <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign div_start = div_start_q;
  assign div_m     = div_m_q;
  assign div_q     = div_q_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_quot  = rsp_quot_q;
  assign rsp_rem   = rsp_rem_q;
  assign rsp_dbz   = rsp_dbz_q;
  assign rsp_tmo   = rsp_tmo_q;
  assign busy      = busy_q;

endmodule
